// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing (SC) blocks.
//   sc_dec_state_t : decoder FSM state (SC_IDLE, SC_ACCUM)
//   sc_window_len  : window length 2^n for a log2 window size n
//   sc_bipolar     : unipolar ones-count to bipolar value, 2*count - 2^n
package sc_pkg;

  typedef logic [0:0] sc_dec_state_t;

  localparam sc_dec_state_t SC_IDLE  = 1'b0;
  localparam sc_dec_state_t SC_ACCUM = 1'b1;

  function automatic logic [31:0] sc_window_len(input int unsigned n);
    return 32'd1 << n;
  endfunction

  // Result is 32-bit two's complement; callers truncate to their width,
  // which is exact as long as the width holds -2^n..+2^n (n+2 bits).
  function automatic logic signed [31:0] sc_bipolar(input logic [31:0] count,
                                                    input int unsigned n);
    return $signed({count[30:0], 1'b0}) - $signed(sc_window_len(n));
  endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Window counter for the stochastic bitstream decoder.
// Counts enabled samples and ones over a window of 2^N samples.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : abandon the current window (counters to 0)
//   sample     : this cycle is an enabled sample (already qualified by clear)
//   bit_in     : stochastic bit, used only when sample=1
//   last       : strobe, this sample completes the window
//   final_sum  : ones in the window including the current bit (0..2^N)
module sc_window_counter
  import sc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         sample,
  input  logic         bit_in,
  output logic         last,
  output logic [N:0]   final_sum
);

  logic [N-1:0] sample_cnt_p0;
  logic [N:0]   ones_cnt_p0;

  assign last      = sample && (sample_cnt_p0 == N'(sc_window_len(N) - 32'd1));
  assign final_sum = ones_cnt_p0 + {{N{1'b0}}, bit_in};

  // Counter stage: the final sample returns both counters to 0 so the next
  // window can start on the very next enabled cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sample_cnt_p0 <= '0;
      ones_cnt_p0   <= '0;
    end else if (sample) begin
      if (last) begin
        sample_cnt_p0 <= '0;
        ones_cnt_p0   <= '0;
      end else begin
        sample_cnt_p0 <= sample_cnt_p0 + 1'b1;
        ones_cnt_p0   <= final_sum;
      end
    end
  end

endmodule

// File: rtl/sc_bitstream_decoder.sv
// Stochastic-to-binary converter: counts the ones of a unipolar bitstream
// over 2^N enabled samples and offers the count on a valid/ready output.
// The input is not stallable; a completed window that finds the output
// register occupied is dropped and the sticky overflow flag is raised.
//   clk, rst   : clock, synchronous active-high reset
//   bit_in     : stochastic bit, sampled when enable=1
//   enable     : sample qualifier
//   restart    : abandon current window, clear overflow (pending output kept)
//   out_data   : N+2-bit result (unsigned count, or bipolar value)
//   out_valid  : out_data holds an undelivered result
//   out_ready  : consumer accepts; transfer on out_valid && out_ready
//   overflow   : sticky, at least one completed window was dropped
// Build option: define SC_DECODER_BIPOLAR_EN to present 2*count - 2^N as a
// two's-complement value instead of the zero-extended count.
module sc_bitstream_decoder
  import sc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_in,
  input  logic         enable,
  input  logic         restart,
  output logic [N+1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overflow
);

  sc_dec_state_t state_p0;
  logic          sample;
  logic          last;
  logic [N:0]    final_sum;
  logic [N+1:0]  result_conv;
  logic          out_free;
  logic          xfer;

  // restart wins over the sample, so a bit arriving with restart is lost
  // and a restart on the final sample yields no result.
  assign sample = enable && !restart;

  sc_window_counter #(
    .N (N)
  ) u_window_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (restart),
    .sample    (sample),
    .bit_in    (bit_in),
    .last      (last),
    .final_sum (final_sum)
  );

`ifdef SC_DECODER_BIPOLAR_EN
  assign result_conv = (N+2)'(sc_bipolar(32'(final_sum), N));
`else
  assign result_conv = {1'b0, final_sum};
`endif

  assign xfer     = out_valid && out_ready;
  assign out_free = !out_valid || out_ready;

  // FSM stage
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      state_p0 <= SC_IDLE;
    end else if (sample) begin
      case (state_p0)
        SC_IDLE:  state_p0 <= last ? SC_IDLE : SC_ACCUM;
        SC_ACCUM: if (last) state_p0 <= SC_IDLE;
        default:  state_p0 <= SC_IDLE;
      endcase
    end
  end

  // Output register stage: a result may load on the same edge that the
  // previous one is drained, which keeps back-to-back windows lossless.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (last && out_free) begin
        out_valid <= 1'b1;
        out_data  <= result_conv;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end

      if (restart) begin
        overflow <= 1'b0;
      end else if (last && !out_free) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
module tb_sc_bitstream_decoder;

  localparam int N   = 4;
  localparam int WIN = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         bit_in = 1'b0;
  logic         enable = 1'b0;
  logic         restart = 1'b0;
  logic [N+1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: samples and ones seen in the current window,
  // plus the output slot and sticky drop flag.
  int           m_cnt   = 0;
  int           m_ones  = 0;
  bit           m_valid = 1'b0;
  bit           m_ovf   = 1'b0;
  logic [N+1:0] m_data  = '0;

  always #5 clk = ~clk;

  sc_bitstream_decoder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .enable    (enable),
    .restart   (restart),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  function automatic logic [N+1:0] exp_conv(input int r);
    int v;
`ifdef SC_DECODER_BIPOLAR_EN
    v = 2 * r - WIN;
`else
    v = r;
`endif
    return (N+2)'(v);
  endfunction

  // Drive one cycle and advance the model across the same clock edge.
  task automatic step(input bit en, input bit b, input bit rs, input bit rdy,
                      input bit r = 1'b0);
    bit took;
    enable = en; bit_in = b; restart = rs; out_ready = rdy; rst = r;
    @(posedge clk);
    took = m_valid && rdy;
    if (r) begin
      m_cnt = 0; m_ones = 0; m_valid = 0; m_ovf = 0; m_data = '0;
    end else if (rs) begin
      m_cnt = 0; m_ones = 0; m_ovf = 0;
      if (took) m_valid = 0;
    end else begin
      if (took) m_valid = 0;
      if (en) begin
        m_cnt++;
        m_ones += int'(b);
        if (m_cnt == WIN) begin
          if (!m_valid) begin
            m_valid = 1;
            m_data  = exp_conv(m_ones);
          end else begin
            m_ovf = 1;
          end
          m_cnt = 0; m_ones = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL reset_data: got %0d want 0", out_data); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < WIN; i++) begin
      step(1, 1, 0, 1);
      if (i < WIN - 1) begin
        n_checks++; if (out_valid !== 1'b0) $display("FAIL all_ones_early: got %b want 0 at %0d", out_valid, i); else n_pass++;
      end
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL all_ones_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== exp_conv(16)) $display("FAIL all_ones_data: got %0d want %0d", out_data, exp_conv(16)); else n_pass++;
    step(0, 0, 0, 1);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL all_ones_one_cycle: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_alternating_gaps();
    int k = 0;
    int cyc = 0;
    while (k < WIN) begin
      if (cyc % 3 == 2) begin
        step(0, 1, 0, 1);
      end else begin
        step(1, (k % 2 == 0), 0, 1);
        k++;
      end
      cyc++;
      if (k < WIN) begin
        n_checks++; if (out_valid !== 1'b0) $display("FAIL alt_early: got %b want 0 at sample %0d", out_valid, k); else n_pass++;
      end
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL alt_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== exp_conv(8)) $display("FAIL alt_data: got %0d want %0d", out_data, exp_conv(8)); else n_pass++;
    step(0, 0, 0, 1);
  endtask

  task automatic test_overflow_drop();
    for (int i = 0; i < WIN; i++) step(1, (i < 5), 0, 0);
    n_checks++; if (out_data !== exp_conv(5)) $display("FAIL ovf_first_data: got %0d want %0d", out_data, exp_conv(5)); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_first_flag: got %b want 0", overflow); else n_pass++;
    for (int i = 0; i < WIN; i++) step(1, (i < 9), 0, 0);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL ovf_held_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== exp_conv(5)) $display("FAIL ovf_held_data: got %0d want %0d", out_data, exp_conv(5)); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
    step(0, 0, 0, 1);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL ovf_drain: got %b want 0", out_valid); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1);
      n_checks++; if (out_valid !== 1'b0) $display("FAIL ovf_no_second: got %b want 0", out_valid); else n_pass++;
    end
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
    step(0, 0, 1, 1);
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_restart_clear: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_drain_same_cycle();
    for (int i = 0; i < WIN; i++) step(1, (i < 3), 0, 0);
    n_checks++; if (out_data !== exp_conv(3)) $display("FAIL drain_first: got %0d want %0d", out_data, exp_conv(3)); else n_pass++;
    for (int i = 0; i < WIN - 1; i++) step(1, (i < 7), 0, 0);
    step(1, 0, 0, 1);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL drain_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== exp_conv(7)) $display("FAIL drain_data: got %0d want %0d", out_data, exp_conv(7)); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL drain_overflow: got %b want 0", overflow); else n_pass++;
    step(0, 0, 0, 1);
  endtask

  task automatic test_restart();
    for (int i = 0; i < WIN; i++) step(1, (i < 2), 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL restart_pending_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== exp_conv(2)) $display("FAIL restart_pending_data: got %0d want %0d", out_data, exp_conv(2)); else n_pass++;
    for (int i = 0; i < WIN; i++) begin
      step(1, (i < 3), 0, 1);
      if (i == 0) begin
        n_checks++; if (out_valid !== 1'b0) $display("FAIL restart_delivered: got %b want 0", out_valid); else n_pass++;
      end
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL restart_new_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== exp_conv(3)) $display("FAIL restart_new_data: got %0d want %0d", out_data, exp_conv(3)); else n_pass++;
    step(0, 0, 0, 1);
    for (int i = 0; i < WIN - 1; i++) step(1, 1, 0, 1);
    step(1, 1, 1, 1);
    step(0, 0, 0, 1);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL restart_final_sample: got %b want 0", out_valid); else n_pass++;
    for (int i = 0; i < WIN; i++) step(1, 0, 0, 1);
    n_checks++; if (out_data !== exp_conv(0)) $display("FAIL restart_zero_window: got %0d want %0d", out_data, exp_conv(0)); else n_pass++;
    step(0, 0, 0, 1);
  endtask

  task automatic test_rst_mid_window();
    for (int i = 0; i < WIN; i++) step(1, (i < 6), 0, 0);
    for (int i = 0; i < WIN; i++) step(1, (i < 1), 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    n_checks++; if (overflow !== 1'b1) $display("FAIL rst_pre_overflow: got %b want 1", overflow); else n_pass++;
    step(1, 1, 0, 0, 1);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL rst_data: got %0d want 0", out_data); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow); else n_pass++;
    for (int i = 0; i < WIN; i++) step(1, (i < 11), 0, 1);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rst_new_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== exp_conv(11)) $display("FAIL rst_new_data: got %0d want %0d", out_data, exp_conv(11)); else n_pass++;
    step(0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit en, b, rs, rdy, r;
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      b   = $urandom_range(0, 1);
      rs  = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      r   = ($urandom_range(0, 499) == 0);
      step(en, b, rs, rdy, r);
      n_checks++; if (out_valid !== m_valid) $display("FAIL rand_valid cyc %0d: got %b want %b", i, out_valid, m_valid); else n_pass++;
      if (m_valid) begin
        n_checks++; if (out_data !== m_data) $display("FAIL rand_data cyc %0d: got %0d want %0d", i, out_data, m_data); else n_pass++;
      end
      n_checks++; if (overflow !== m_ovf) $display("FAIL rand_overflow cyc %0d: got %b want %b", i, overflow, m_ovf); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_alternating_gaps();
    test_overflow_drop();
    test_drain_same_cycle();
    test_restart();
    test_rst_mid_window();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
